// File: rtl/arb_mux_4_1.sv
// Four-way arbiter with array-indexed data mux and a single registered output stage.
// Define ARB_MUX_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module arb_mux_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_id,
   input  logic               out_ready
);

   logic [WIDTH-1:0] word [4];
   logic [1:0]       gnt_id;
   logic             found;
   logic             any_req;
   logic             load_en;
   logic             xfer;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         word[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign any_req = |in_valid;
   assign load_en = ~out_valid | out_ready;
   // Reset gates the handshake so no producer sees an accept during the reset cycle.
   assign xfer    = any_req & load_en & ~rst;

`ifdef ARB_MUX_FIXED_PRIO_EN
   always_comb begin
      gnt_id = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!found && in_valid[i]) begin
            gnt_id = 2'(i);
            found  = 1'b1;
         end
      end
   end
`else
   logic [1:0] lg;
   logic [1:0] idx;

   // Search starts just past the last winner; the 2-bit add wraps mod 4.
   always_comb begin
      gnt_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = lg + 2'(k);
         if (!found && in_valid[idx]) begin
            gnt_id = idx;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lg <= 2'd3;
      end else if (xfer) begin
         lg <= gnt_id;
      end
   end
`endif

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         in_ready[i] = xfer & found & (gnt_id == 2'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else if (load_en) begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= word[gnt_id];
            out_id    <= gnt_id;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Self-checking bench for arb_mux_4_1: directed scenarios plus randomized traffic
// checked against a queue-free behavioural model of the arbitration rules.
module tb_arb_mux_4_1;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     in_valid;
   logic [4*W-1:0] in_data;
   logic [3:0]     in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_id;
   logic           out_ready;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] word [4];

   // model state
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_id;
   int           m_lg;

   arb_mux_4_1 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] v);
`ifdef ARB_MUX_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
      for (int k = 1; k <= 4; k++) begin
         int c = (m_lg + k) % 4;
         if (v[c]) return c;
      end
`endif
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      int p;
      if (rst) return 4'b0000;
      if (m_valid && !out_ready) return 4'b0000;
      p = pick(in_valid);
      if (p < 0) return 4'b0000;
      return 4'(1 << p);
   endfunction

   task automatic drive(input logic [3:0] v, input logic ordy, input logic r);
      in_valid  = v;
      out_ready = ordy;
      rst       = r;
      in_data   = {word[3], word[2], word[1], word[0]};
      #1;
   endtask

   task automatic tick();
      logic [3:0] er = exp_ready();
      int p = pick(in_valid);
      bit le = !m_valid || out_ready;
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = '0; m_id = 0; m_lg = 3;
      end else if (er != 4'b0000) begin
         m_valid = 1; m_data = word[p]; m_id = p; m_lg = p;
      end else if (le) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         drive(4'b1111, 1'b1, 1'b1);
         total++;
         if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
         tick();
         total++;
         if (out_valid !== 1'b0 || out_data !== '0 || out_id !== 2'd0) begin
            bad++; $display("FAIL reset_out got v=%b d=%h id=%0d exp v=0 d=0 id=0", out_valid, out_data, out_id);
         end
      end
   endtask

   task automatic test_round_robin();
      word[0] = 4'hA; word[1] = 4'hB; word[2] = 4'hC; word[3] = 4'hD;
      for (int c = 0; c < 8; c++) begin
`ifdef ARB_MUX_FIXED_PRIO_EN
         int e = 0;
`else
         int e = c % 4;
`endif
         drive(4'b1111, 1'b1, 1'b0);
         total++;
         if (in_ready !== 4'(1 << e)) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, in_ready, 4'(1 << e)); end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_id !== 2'(e) || out_data !== word[e]) begin
            bad++; $display("FAIL rr_out cyc=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", c, out_valid, out_id, out_data, e, word[e]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] er;
      int e;
      drive(4'b0010, 1'b1, 1'b0);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 4'hB) begin
         bad++; $display("FAIL bp_load got v=%b id=%0d d=%h exp v=1 id=1 d=b", out_valid, out_id, out_data);
      end
      for (int c = 0; c < 3; c++) begin
         drive(4'b1101, 1'b0, 1'b0);
         total++;
         if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, in_ready); end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 4'hB) begin
            bad++; $display("FAIL bp_hold cyc=%0d got v=%b id=%0d d=%h exp v=1 id=1 d=b", c, out_valid, out_id, out_data);
         end
      end
`ifdef ARB_MUX_FIXED_PRIO_EN
      er = 4'b0001; e = 0;
`else
      er = 4'b0100; e = 2;
`endif
      drive(4'b1101, 1'b1, 1'b0);
      total++;
      if (in_ready !== er) begin bad++; $display("FAIL bp_release_ready got=%b exp=%b", in_ready, er); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'(e) || out_data !== word[e]) begin
         bad++; $display("FAIL bp_release_out got id=%0d d=%h exp id=%0d d=%h", out_id, out_data, e, word[e]);
      end
   endtask

   task automatic test_skip_wrap();
      int seq [3];
      logic [3:0] vin [3];
      vin[0] = 4'b0010; vin[1] = 4'b1001; vin[2] = 4'b1001;
`ifdef ARB_MUX_FIXED_PRIO_EN
      seq[0] = 1; seq[1] = 0; seq[2] = 0;
`else
      seq[0] = 1; seq[1] = 3; seq[2] = 0;
`endif
      for (int c = 0; c < 3; c++) begin
         drive(vin[c], 1'b1, 1'b0);
         total++;
         if (in_ready !== 4'(1 << seq[c])) begin bad++; $display("FAIL skip_ready step=%0d got=%b exp=%b", c, in_ready, 4'(1 << seq[c])); end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_id !== 2'(seq[c])) begin
            bad++; $display("FAIL skip_out step=%0d got v=%b id=%0d exp v=1 id=%0d", c, out_valid, out_id, seq[c]);
         end
      end
   endtask

   task automatic test_idle_drain();
      word[0] = 4'h5;
      drive(4'b0001, 1'b1, 1'b0);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'h5 || out_id !== 2'd0) begin
         bad++; $display("FAIL drain_load got v=%b d=%h id=%0d exp v=1 d=5 id=0", out_valid, out_data, out_id);
      end
      drive(4'b0000, 1'b1, 1'b0);
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL drain_ready got=%b exp=0000", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got v=%b exp v=0", out_valid); end
   endtask

   task automatic test_reset_mid_hold();
      drive(4'b0100, 1'b1, 1'b0);
      tick();
      drive(4'b1111, 1'b0, 1'b1);
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready got=%b exp=0000", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out got v=%b exp v=0", out_valid); end
      drive(4'b1010, 1'b1, 1'b0);
      total++;
      if (in_ready !== 4'b0010) begin bad++; $display("FAIL midrst_first_ready got=%b exp=0010", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== word[1]) begin
         bad++; $display("FAIL midrst_first_out got v=%b id=%0d d=%h exp v=1 id=1 d=%h", out_valid, out_id, out_data, word[1]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         logic [3:0] er;
         for (int i = 0; i < 4; i++) word[i] = W'($urandom);
         drive(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
         er = exp_ready();
         total++;
         if (in_ready !== er) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, er); end
         tick();
         total++;
         if (out_valid !== m_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, out_valid, m_valid); end
         else if (m_valid && (out_id !== 2'(m_id) || out_data !== m_data)) begin
            bad++; $display("FAIL rand_out cyc=%0d got id=%0d d=%h exp id=%0d d=%h", c, out_id, out_data, m_id, m_data);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; out_ready = 1'b1; in_data = '0;
      for (int i = 0; i < 4; i++) word[i] = '0;
      m_valid = 0; m_data = '0; m_id = 0; m_lg = 3;
      @(posedge clk); #1;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_skip_wrap();
      test_idle_drain();
      test_reset_mid_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
